rr_arbiter4: RTL

Four-requester round-robin arbiter with grant hold, timeout and one-hot grant decode. It sits in front of a shared 4-way resource (bus, memory port or functional unit) and emits a 2-bit owner index alongside its 2-to-4 one-hot expansion, so downstream enables are driven directly. Fairness is rotating priority. A hold-timeout stops any single requester from monopolising the resource.

---
 rtl/rr_arbiter4.sv | 119 +++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant hold limit,
// one-cycle turnaround gap and registered one-hot grant decode.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // hold_cnt reaching HoldLast means the owner has held HOLD_MAX cycles
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] HoldMax  = CW'(HOLD_MAX);

  logic [1:0]    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    winner;
  logic [1:0]    cand;

  function automatic logic [3:0] decode(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Rotating-priority pick: scan from the farthest offset down so the
  // requester closest to ptr is assigned last and wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) winner = cand;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_id_d  = gnt_id_q;
    gnt_d     = 4'b0000;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          gnt_id_d = winner;
          hold_d   = '0;
          gnt_d    = decode(winner);
          valid_d  = 1'b1;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          // Normal release wins even if the limit is reached this cycle.
          state_d = GAP;
          ptr_d   = gnt_id_q + 2'd1;
        end else if (hold_q == HoldLast) begin
          state_d   = GAP;
          ptr_d     = gnt_id_q + 2'd1;
          timeout_d = 1'b1;
        end else begin
          gnt_d   = decode(gnt_id_q);
          valid_d = 1'b1;
          if (hold_q != HoldMax) hold_d = hold_q + CW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
      gnt_id_q  <= 2'd0;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_id_q  <= gnt_id_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
